// File: rtl/decoder_para_seq_if.sv
// ============================================================================
// Module   : decoder_para_seq_if
// Brief    : Request handshake and one-hot output bundle for decoder_para_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decoder_para_seq_if #(
  parameter int N      = 3,
  parameter int HOLD_W = 4
);
  localparam int M = 1 << N;

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_idx;
  logic [HOLD_W-1:0] in_hold;
  logic [M-1:0]      out;
  logic              out_valid;
  logic              busy;

  modport master (
    output in_valid, in_idx, in_hold,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  in_valid, in_idx, in_hold,
    output in_ready, out, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/decoder_para_seq.sv
// ============================================================================
// Module   : decoder_para_seq
// Brief    : Registered N-to-2^N one-hot decoder with per-request hold time
//            and a one-entry pending buffer for gap-free back-to-back requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_para_seq #(
  parameter int N      = 3,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  decoder_para_seq_if.slave bus
);
  localparam int M = 1 << N;
  localparam logic [M-1:0]      c_one     = {{(M-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] c_cnt_one = {{(HOLD_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [M-1:0]      r_out,       w_out_nxt;
  logic [HOLD_W-1:0] r_cnt,       w_cnt_nxt;
  logic              r_pend_full, w_pend_full_nxt;
  logic [N-1:0]      r_pend_idx,  w_pend_idx_nxt;
  logic [HOLD_W-1:0] r_pend_hold, w_pend_hold_nxt;

  logic              w_ready;
  logic              w_accept;
  logic [HOLD_W-1:0] w_hold_eff;

  assign w_ready    = !clr && !r_pend_full;
  assign w_accept   = bus.in_valid && w_ready;
  assign w_hold_eff = (bus.in_hold == '0) ? c_cnt_one : bus.in_hold;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_out       <= '0;
      r_cnt       <= '0;
      r_pend_full <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_hold <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_pend_idx  <= w_pend_idx_nxt;
      r_pend_hold <= w_pend_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_cnt_nxt       = r_cnt;
    w_pend_full_nxt = r_pend_full;
    w_pend_idx_nxt  = r_pend_idx;
    w_pend_hold_nxt = r_pend_hold;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_out_nxt   = c_one << bus.in_idx;
          w_cnt_nxt   = w_hold_eff;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt > c_cnt_one) begin
          w_cnt_nxt = r_cnt - c_cnt_one;
          if (w_accept) begin
            w_pend_full_nxt = 1'b1;
            w_pend_idx_nxt  = bus.in_idx;
            w_pend_hold_nxt = w_hold_eff;
          end
        end else if (r_pend_full) begin
          w_out_nxt       = c_one << r_pend_idx;
          w_cnt_nxt       = r_pend_hold;
          w_pend_full_nxt = 1'b0;
        end else if (w_accept) begin
          // Last cycle of the active request: a fresh request skips the buffer.
          w_out_nxt = c_one << bus.in_idx;
          w_cnt_nxt = w_hold_eff;
        end else begin
          w_out_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_out_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = w_ready;
  assign bus.out       = r_out;
  assign bus.out_valid = (r_state == ST_DRIVE);
  assign bus.busy      = (r_state == ST_DRIVE) || r_pend_full;

endmodule

`default_nettype wire

// File: tb/tb_decoder_para_seq.sv
// ============================================================================
// Module   : tb_decoder_para_seq
// Brief    : Directed and randomized bench for decoder_para_seq against a
//            request-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_para_seq;
  logic clk;
  logic clr;

  decoder_para_seq_if #(.N(3), .HOLD_W(4)) bus ();

  decoder_para_seq #(.N(3), .HOLD_W(4)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int h;
  } req_t;

  req_t q[$];
  int   act_valid;
  int   act_idx;
  int   act_rem;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input logic c, input logic v, input int idx, input int hold,
                       output logic acc);
    logic m_ready;
    req_t r;
    int   exp_out;
    clr          = c;
    bus.in_valid = v;
    bus.in_idx   = idx[2:0];
    bus.in_hold  = hold[3:0];
    #1;
    m_ready = !c && (q.size() == 0);
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready});
    acc = v && m_ready;
    @(posedge clk);
    if (c) begin
      q.delete();
      act_valid = 0;
      act_rem   = 0;
    end else begin
      if (act_valid != 0) begin
        act_rem--;
        if (act_rem == 0) act_valid = 0;
      end
      if (acc) begin
        r.idx = idx;
        r.h   = (hold == 0) ? 1 : hold;
        q.push_back(r);
      end
      if (act_valid == 0 && q.size() > 0) begin
        r         = q.pop_front();
        act_valid = 1;
        act_idx   = r.idx;
        act_rem   = r.h;
      end
    end
    exp_out = (act_valid != 0) ? (1 << act_idx) : 0;
    #1;
    chk("out",       {24'b0, bus.out},       exp_out);
    chk("out_valid", {31'b0, bus.out_valid}, act_valid);
    chk("busy",      {31'b0, bus.busy},      ((act_valid != 0) || q.size() > 0) ? 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    logic req_v;
    int   req_idx;
    int   req_hold;
    n_checks  = 0;
    n_errors  = 0;
    act_valid = 0;
    act_idx   = 0;
    act_rem   = 0;
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_hold  = '0;
    @(negedge clk);

    // Reset with a request waiting upstream
    cycle(1, 1, 3, 1, acc);
    cycle(1, 1, 3, 1, acc);
    chk("rst_acc",   {31'b0, acc},           0);
    chk("rst_out",   {24'b0, bus.out},       32'h00);
    chk("rst_valid", {31'b0, bus.out_valid}, 0);
    cycle(0, 1, 3, 1, acc);
    chk("post_rst_acc", {31'b0, acc}, 1);
    chk("post_rst_out", {24'b0, bus.out}, 32'h08);
    cycle(0, 0, 0, 0, acc);
    chk("post_rst_end", {24'b0, bus.out}, 32'h00);

    // Single request idx=5 hold=3
    cycle(0, 1, 5, 3, acc);
    chk("sgl_t1", {24'b0, bus.out}, 32'h20);
    cycle(0, 0, 0, 0, acc);
    chk("sgl_t2", {24'b0, bus.out}, 32'h20);
    cycle(0, 0, 0, 0, acc);
    chk("sgl_t3", {24'b0, bus.out}, 32'h20);
    cycle(0, 0, 0, 0, acc);
    chk("sgl_t4", {24'b0, bus.out}, 32'h00);
    chk("sgl_t4v", {31'b0, bus.out_valid}, 0);

    // Zero hold behaves as one cycle
    cycle(0, 1, 0, 0, acc);
    chk("zh_t1", {24'b0, bus.out}, 32'h01);
    cycle(0, 0, 0, 0, acc);
    chk("zh_t2", {24'b0, bus.out}, 32'h00);

    // Back-to-back with a stalled third request
    cycle(0, 1, 2, 2, acc);
    chk("b2b_a", {24'b0, bus.out}, 32'h04);
    cycle(0, 1, 7, 1, acc);
    chk("b2b_b_acc", {31'b0, acc}, 1);
    chk("b2b_b", {24'b0, bus.out}, 32'h04);
    cycle(0, 1, 1, 1, acc);
    chk("stall1_acc", {31'b0, acc}, 0);
    chk("stall1_out", {24'b0, bus.out}, 32'h80);
    chk("stall1_busy", {31'b0, bus.busy}, 1);
    cycle(0, 1, 1, 1, acc);
    chk("stall2_acc", {31'b0, acc}, 1);
    chk("stall2_out", {24'b0, bus.out}, 32'h02);
    cycle(0, 0, 0, 0, acc);
    chk("b2b_end", {24'b0, bus.out}, 32'h00);

    // Same index back-to-back stays high for the summed hold
    cycle(0, 1, 6, 1, acc);
    cycle(0, 1, 6, 2, acc);
    chk("rep_t2", {24'b0, bus.out}, 32'h40);
    cycle(0, 0, 0, 0, acc);
    chk("rep_t3", {24'b0, bus.out}, 32'h40);
    cycle(0, 0, 0, 0, acc);
    chk("rep_end", {24'b0, bus.out}, 32'h00);

    // Reset mid-drive discards active and pending requests
    cycle(0, 1, 4, 8, acc);
    cycle(0, 1, 6, 1, acc);
    chk("mid_pend_acc", {31'b0, acc}, 1);
    cycle(0, 0, 0, 0, acc);
    cycle(1, 0, 0, 0, acc);
    chk("mid_out",  {24'b0, bus.out},       32'h00);
    chk("mid_val",  {31'b0, bus.out_valid}, 0);
    chk("mid_busy", {31'b0, bus.busy},      0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, acc);
      chk("mid_no6", {31'b0, (bus.out == 8'h40)}, 0);
    end

    // Randomized traffic with occasional resets
    req_v    = 1'b0;
    req_idx  = 0;
    req_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!req_v && $urandom_range(0, 99) < 60) begin
        req_v    = 1'b1;
        req_idx  = int'($urandom_range(0, 7));
        req_hold = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 2));
      end
      cycle(($urandom_range(0, 199) == 0), req_v, req_idx, req_hold, acc);
      if (acc) req_v = 1'b0;
    end

    cycle(1, 0, 0, 0, acc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
